pe_layer_sequencer: RTL and testbench

Layer-level controller for a single Eyeriss-v1 PE wrapper. On a start pulse it configures the PE with the layer shape and streams ifmap, filter and ipsum words from three local read-only buffers into the PE input FIFOs, honouring their full flags. It drains opsum words from the PE output FIFO into an output buffer and signals done. It replaces testbench-driven feeding in the PE-array top level.

---
 rtl/pe_layer_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_pe_layer_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pe_layer_sequencer                                                         |
// | Configures one PE for a layer, feeds its input FIFOs from local buffers    |
// | and drains its opsum FIFO into the output buffer.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module pe_layer_feeder #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  run,
   input  logic [ADDR_WIDTH-1:0] count,
   input  logic                  full,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  push,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  finished
);
   logic [ADDR_WIDTH-1:0] sent_q, sent_d;
   logic                  pend_q, pend_d;

   // pend_q marks the PUSH phase: the word read last cycle is on rd_data now
   always_comb begin
      sent_d  = sent_q;
      pend_d  = pend_q;
      rd_en   = 1'b0;
      rd_addr = '0;
      push    = 1'b0;
      data    = '0;
      if (clear) begin
         sent_d = '0;
         pend_d = 1'b0;
      end else if (run) begin
         if (pend_q) begin
            push   = 1'b1;
            data   = rd_data;
            sent_d = sent_q + 1'b1;
            pend_d = 1'b0;
         end else if ((sent_q < count) && !full) begin
            rd_en   = 1'b1;
            rd_addr = sent_q;
            pend_d  = 1'b1;
         end
      end
      finished = (sent_d == count);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sent_q <= '0;
         pend_q <= 1'b0;
      end else begin
         sent_q <= sent_d;
         pend_q <= pend_d;
      end
   end
endmodule

module pe_layer_sequencer #(
   parameter int ADDR_WIDTH        = 12,
   parameter int DATA_WIDTH_IFMAP  = 16,
   parameter int DATA_WIDTH_FILTER = 64,
   parameter int DATA_WIDTH_PSUM   = 64,
   parameter int S_WIDTH           = 5,
   parameter int F_WIDTH           = 6,
   parameter int U_WIDTH           = 3,
   parameter int N_WIDTH           = 3,
   parameter int P_WIDTH           = 5,
   parameter int Q_WIDTH           = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [S_WIDTH-1:0]           layer_S,
   input  logic [F_WIDTH-1:0]           layer_F,
   input  logic [U_WIDTH-1:0]           layer_U,
   input  logic [N_WIDTH-1:0]           layer_n,
   input  logic [P_WIDTH-1:0]           layer_p,
   input  logic [Q_WIDTH-1:0]           layer_q,
   output logic                         busy,
   output logic                         done,
   output logic                         pe_enable,
   output logic                         pe_configure,
   output logic [S_WIDTH-1:0]           pe_S,
   output logic [F_WIDTH-1:0]           pe_F,
   output logic [U_WIDTH-1:0]           pe_U,
   output logic [N_WIDTH-1:0]           pe_n,
   output logic [P_WIDTH-1:0]           pe_p,
   output logic [Q_WIDTH-1:0]           pe_q,
   output logic                         ifmap_rd_en,
   output logic [ADDR_WIDTH-1:0]        ifmap_rd_addr,
   input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap_rd_data,
   output logic                         filter_rd_en,
   output logic [ADDR_WIDTH-1:0]        filter_rd_addr,
   input  logic [DATA_WIDTH_FILTER-1:0] filter_rd_data,
   output logic                         ipsum_rd_en,
   output logic [ADDR_WIDTH-1:0]        ipsum_rd_addr,
   input  logic [DATA_WIDTH_PSUM-1:0]   ipsum_rd_data,
   output logic                         push_ifmap,
   output logic                         push_filter,
   output logic                         push_ipsum,
   output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
   output logic [DATA_WIDTH_FILTER-1:0] filter,
   output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
   input  logic                         ifmap_fifo_full,
   input  logic                         filter_fifo_full,
   input  logic                         ipsum_fifo_full,
   output logic                         pop_opsum,
   input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
   input  logic                         opsum_fifo_empty,
   output logic                         out_wr_en,
   output logic [ADDR_WIDTH-1:0]        out_wr_addr,
   output logic [DATA_WIDTH_PSUM-1:0]   out_wr_data
);
   localparam int CW = ADDR_WIDTH + 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CONFIG = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [S_WIDTH-1:0]    s_q, s_d;
   logic [F_WIDTH-1:0]    f_q, f_d;
   logic [U_WIDTH-1:0]    u_q, u_d;
   logic [N_WIDTH-1:0]    n_q, n_d;
   logic [P_WIDTH-1:0]    p_q, p_d;
   logic [Q_WIDTH-1:0]    q_q, q_d;
   logic [ADDR_WIDTH-1:0] n_ifm_q, n_ifm_d, n_flt_q, n_flt_d, n_psum_q, n_psum_d;
   logic [ADDR_WIDTH-1:0] rcv_q, rcv_d;
   logic                  gap_q, gap_d;
   logic                  pe_enable_q, pe_enable_d;
   logic                  fields_ok, stream_done;
   logic                  ifm_fin, flt_fin, ips_fin;
   logic [ADDR_WIDTH-1:0] w_c, ifm_c;
   logic [CW-1:0]         flt_c, psum_c;

   assign fields_ok = (|layer_S) && (|layer_F) && (|layer_U) &&
                      (|layer_n) && (|layer_p) && (|layer_q);

   // Products wrap modulo the buffer width; the two extra bits feed the >>2
   assign w_c    = (ADDR_WIDTH'(f_q) - ADDR_WIDTH'(1)) * ADDR_WIDTH'(u_q) + ADDR_WIDTH'(s_q);
   assign ifm_c  = ADDR_WIDTH'(n_q) * w_c * ADDR_WIDTH'(q_q);
   assign flt_c  = CW'(p_q) * CW'(q_q) * CW'(s_q);
   assign psum_c = CW'(p_q) * CW'(n_q) * CW'(f_q);

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      f_d      = f_q;
      u_d      = u_q;
      n_d      = n_q;
      p_d      = p_q;
      q_d      = q_q;
      n_ifm_d  = n_ifm_q;
      n_flt_d  = n_flt_q;
      n_psum_d = n_psum_q;
      case (state_q)
         IDLE: begin
            if (start && fields_ok) begin
               s_d     = layer_S;
               f_d     = layer_F;
               u_d     = layer_U;
               n_d     = layer_n;
               p_d     = layer_p;
               q_d     = layer_q;
               state_d = CONFIG;
            end
         end
         CONFIG: begin
            n_ifm_d  = ifm_c;
            n_flt_d  = flt_c[CW-1:2];
            n_psum_d = psum_c[CW-1:2];
            state_d  = STREAM;
         end
         STREAM:  if (stream_done) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign pe_configure = (state_q == CONFIG);
   assign pe_S         = pe_configure ? s_q : '0;
   assign pe_F         = pe_configure ? f_q : '0;
   assign pe_U         = pe_configure ? u_q : '0;
   assign pe_n         = pe_configure ? n_q : '0;
   assign pe_p         = pe_configure ? p_q : '0;
   assign pe_q         = pe_configure ? q_q : '0;
   assign pe_enable_d  = 1'b1;
   assign pe_enable    = pe_enable_q;

   pe_layer_feeder #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH_IFMAP)) u_ifmap_feeder (
      .clk(clk), .reset(reset), .clear(pe_configure), .run(state_q == STREAM),
      .count(n_ifm_q), .full(ifmap_fifo_full), .rd_data(ifmap_rd_data),
      .rd_en(ifmap_rd_en), .rd_addr(ifmap_rd_addr), .push(push_ifmap),
      .data(ifmap), .finished(ifm_fin)
   );

   pe_layer_feeder #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH_FILTER)) u_filter_feeder (
      .clk(clk), .reset(reset), .clear(pe_configure), .run(state_q == STREAM),
      .count(n_flt_q), .full(filter_fifo_full), .rd_data(filter_rd_data),
      .rd_en(filter_rd_en), .rd_addr(filter_rd_addr), .push(push_filter),
      .data(filter), .finished(flt_fin)
   );

   pe_layer_feeder #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH_PSUM)) u_ipsum_feeder (
      .clk(clk), .reset(reset), .clear(pe_configure), .run(state_q == STREAM),
      .count(n_psum_q), .full(ipsum_fifo_full), .rd_data(ipsum_rd_data),
      .rd_en(ipsum_rd_en), .rd_addr(ipsum_rd_addr), .push(push_ipsum),
      .data(ipsum), .finished(ips_fin)
   );

   // Collector: gap_q forces an idle cycle after each pop so empty can settle
   always_comb begin
      rcv_d       = rcv_q;
      gap_d       = 1'b0;
      pop_opsum   = 1'b0;
      out_wr_en   = 1'b0;
      out_wr_addr = '0;
      out_wr_data = '0;
      if (state_q == CONFIG) begin
         rcv_d = '0;
      end else if ((state_q == STREAM) && !gap_q && !opsum_fifo_empty && (rcv_q < n_psum_q)) begin
         pop_opsum   = 1'b1;
         out_wr_en   = 1'b1;
         out_wr_addr = rcv_q;
         out_wr_data = opsum;
         rcv_d       = rcv_q + 1'b1;
         gap_d       = 1'b1;
      end
   end

   // Looks at next-cycle counts so done follows the final transfer directly
   assign stream_done = ifm_fin && flt_fin && ips_fin && (rcv_d == n_psum_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         s_q         <= '0;
         f_q         <= '0;
         u_q         <= '0;
         n_q         <= '0;
         p_q         <= '0;
         q_q         <= '0;
         n_ifm_q     <= '0;
         n_flt_q     <= '0;
         n_psum_q    <= '0;
         rcv_q       <= '0;
         gap_q       <= 1'b0;
         pe_enable_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         f_q         <= f_d;
         u_q         <= u_d;
         n_q         <= n_d;
         p_q         <= p_d;
         q_q         <= q_d;
         n_ifm_q     <= n_ifm_d;
         n_flt_q     <= n_flt_d;
         n_psum_q    <= n_psum_d;
         rcv_q       <= rcv_d;
         gap_q       <= gap_d;
         pe_enable_q <= pe_enable_d;
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_pe_layer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pe_layer_sequencer                                                      |
// | Directed bench: buffer/FIFO models around pe_layer_sequencer.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pe_layer_sequencer;
   localparam int M_BUSY   = 1;
   localparam int M_STALL  = 2;
   localparam int M_TOGGLE = 4;
   localparam int M_RST    = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b0, start = 1'b0;
   logic [4:0]  layer_S = '0, layer_p = '0;
   logic [5:0]  layer_F = '0;
   logic [2:0]  layer_U = '0, layer_n = '0, layer_q = '0;
   logic        busy, done, pe_enable, pe_configure;
   logic [4:0]  pe_S, pe_p;
   logic [5:0]  pe_F;
   logic [2:0]  pe_U, pe_n, pe_q;
   logic        ifmap_rd_en, filter_rd_en, ipsum_rd_en;
   logic [11:0] ifmap_rd_addr, filter_rd_addr, ipsum_rd_addr, out_wr_addr;
   logic [15:0] ifmap_rd_data = '0, ifmap;
   logic [63:0] filter_rd_data = '0, ipsum_rd_data = '0, filter, ipsum, opsum, out_wr_data;
   logic        push_ifmap, push_filter, push_ipsum, pop_opsum, out_wr_en;
   logic        ifmap_fifo_full = 1'b0, filter_fifo_full = 1'b0, ipsum_fifo_full = 1'b0;
   logic        opsum_fifo_empty, empty_force = 1'b0, opsum_rst = 1'b0;
   int          opsum_idx = 0, opsum_avail = 0;

   int n_cmp = 0, n_err = 0, cyc = 0;
   int ifm_rd_n, flt_rd_n, ips_rd_n, ifm_push_n, flt_push_n, ips_push_n, wr_n;
   int done_n, done_cyc, last_evt, flt_stall_n, ips_stall_n;
   logic ifm_prev, flt_prev, ips_prev, pop_prev;

   function automatic logic [15:0] ifm_pat(input int a);
      return 16'(a * 37 + 32'h1100);
   endfunction
   function automatic logic [63:0] flt_pat(input int a);
      return {32'hF17E_0000 + 32'(a), 32'(a * 5 + 1)};
   endfunction
   function automatic logic [63:0] ips_pat(input int a);
      return {16'h1B50, 16'(a), 32'(a * 11)};
   endfunction
   function automatic logic [63:0] psum_pat(input int a);
      return {32'h0B5A_0000 | 32'(a), 32'(a * 3 + 7)};
   endfunction

   assign opsum            = psum_pat(opsum_idx);
   assign opsum_fifo_empty = empty_force || (opsum_idx >= opsum_avail);

   // Read-only buffers (1-cycle latency) and a show-ahead opsum FIFO
   always @(posedge clk) begin
      if (ifmap_rd_en)  ifmap_rd_data  <= ifm_pat(int'(ifmap_rd_addr));
      if (filter_rd_en) filter_rd_data <= flt_pat(int'(filter_rd_addr));
      if (ipsum_rd_en)  ipsum_rd_data  <= ips_pat(int'(ipsum_rd_addr));
      if (opsum_rst)      opsum_idx <= 0;
      else if (pop_opsum) opsum_idx <= opsum_idx + 1;
   end

   pe_layer_sequencer dut (
      .clk(clk), .reset(reset), .start(start),
      .layer_S(layer_S), .layer_F(layer_F), .layer_U(layer_U),
      .layer_n(layer_n), .layer_p(layer_p), .layer_q(layer_q),
      .busy(busy), .done(done), .pe_enable(pe_enable), .pe_configure(pe_configure),
      .pe_S(pe_S), .pe_F(pe_F), .pe_U(pe_U), .pe_n(pe_n), .pe_p(pe_p), .pe_q(pe_q),
      .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_addr(ifmap_rd_addr), .ifmap_rd_data(ifmap_rd_data),
      .filter_rd_en(filter_rd_en), .filter_rd_addr(filter_rd_addr), .filter_rd_data(filter_rd_data),
      .ipsum_rd_en(ipsum_rd_en), .ipsum_rd_addr(ipsum_rd_addr), .ipsum_rd_data(ipsum_rd_data),
      .push_ifmap(push_ifmap), .push_filter(push_filter), .push_ipsum(push_ipsum),
      .ifmap(ifmap), .filter(filter), .ipsum(ipsum),
      .ifmap_fifo_full(ifmap_fifo_full), .filter_fifo_full(filter_fifo_full),
      .ipsum_fifo_full(ipsum_fifo_full),
      .pop_opsum(pop_opsum), .opsum(opsum), .opsum_fifo_empty(opsum_fifo_empty),
      .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Per-cycle protocol monitor, run at each falling edge
   task automatic monitor();
      cyc++;
      if (pe_configure) begin
         ifm_rd_n = 0; flt_rd_n = 0; ips_rd_n = 0;
         ifm_push_n = 0; flt_push_n = 0; ips_push_n = 0; wr_n = 0;
         done_n = 0; done_cyc = 0; last_evt = cyc;
         flt_stall_n = 0; ips_stall_n = 0;
      end
      if (ifmap_rd_en)  begin check_eq("ifm_rd_addr", ifmap_rd_addr, ifm_rd_n);  ifm_rd_n++; end
      if (filter_rd_en) begin check_eq("flt_rd_addr", filter_rd_addr, flt_rd_n); flt_rd_n++; end
      if (ipsum_rd_en)  begin check_eq("ips_rd_addr", ipsum_rd_addr, ips_rd_n);  ips_rd_n++; end
      if (push_ifmap) begin
         check_eq("ifm_data", ifmap, ifm_pat(ifm_push_n));
         check_eq("ifm_spacing", ifm_prev, 0);
         ifm_push_n++; last_evt = cyc;
      end else check_eq("ifm_idle_zero", ifmap, 0);
      if (push_filter) begin
         check_eq("flt_data", filter, flt_pat(flt_push_n));
         check_eq("flt_spacing", flt_prev, 0);
         flt_push_n++; last_evt = cyc;
         if (ifmap_fifo_full) flt_stall_n++;
      end else check_eq("flt_idle_zero", filter, 0);
      if (push_ipsum) begin
         check_eq("ips_data", ipsum, ips_pat(ips_push_n));
         check_eq("ips_spacing", ips_prev, 0);
         ips_push_n++; last_evt = cyc;
         if (ifmap_fifo_full) ips_stall_n++;
      end else check_eq("ips_idle_zero", ipsum, 0);
      if (ifmap_fifo_full) check_eq("ifm_rd_while_full", ifmap_rd_en, 0);
      if (pop_opsum || out_wr_en) check_eq("pop_wr_pair", pop_opsum, out_wr_en);
      if (out_wr_en) begin
         check_eq("wr_addr", out_wr_addr, wr_n);
         check_eq("wr_data", out_wr_data, psum_pat(wr_n));
         check_eq("pop_spacing", pop_prev, 0);
         wr_n++; last_evt = cyc;
      end
      if (done) begin done_n++; done_cyc = cyc; end
      ifm_prev = push_ifmap; flt_prev = push_filter;
      ips_prev = push_ipsum; pop_prev = pop_opsum;
   endtask

   task automatic sample(); @(negedge clk); monitor(); endtask
   task automatic step();   @(posedge clk); #1;        endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_outs"}, {done, pe_configure, ifmap_rd_en, filter_rd_en, ipsum_rd_en,
               push_ifmap, push_filter, push_ipsum, pop_opsum, out_wr_en}, 0);
      check_eq({tag, "_addr"}, {ifmap_rd_addr, filter_rd_addr, ipsum_rd_addr, out_wr_addr}, 0);
      check_eq({tag, "_pe"}, {pe_S, pe_F, pe_U, pe_n, pe_p, pe_q}, 0);
   endtask

   task automatic run_layer(input int s, input int f, input int u, input int n, input int p,
                            input int q, input int e_ifm, input int e_flt, input int e_psum,
                            input int mode);
      opsum_rst = 1'b1; opsum_avail = e_psum; empty_force = 1'b0; ifmap_fifo_full = 1'b0;
      layer_S = 5'(s); layer_F = 6'(f); layer_U = 3'(u);
      layer_n = 3'(n); layer_p = 5'(p); layer_q = 3'(q);
      start = 1'b1;
      sample(); check_eq("busy_before_start", busy, 0); step();
      start = 1'b0; opsum_rst = 1'b0;
      layer_S = '0; layer_F = '0; layer_U = '0; layer_n = '0; layer_p = '0; layer_q = '0;
      sample();
      check_eq("cfg_pulse", pe_configure, 1);
      check_eq("cfg_shape", {pe_S, pe_F, pe_U, pe_n, pe_p, pe_q},
               {5'(s), 6'(f), 3'(u), 3'(n), 5'(p), 3'(q)});
      check_eq("busy_cfg", busy, 1);
      step(); sample();
      check_eq("first_read_t2", ifmap_rd_en, 1);
      check_eq("no_push_t2", push_ifmap, 0);
      step(); sample();
      check_eq("first_push_t3", push_ifmap, 1);
      step();
      for (int k = 0; k < 3000; k++) begin
         ifmap_fifo_full = ((mode & M_STALL) != 0) && (k >= 20) && (k < 40);
         empty_force     = ((mode & M_TOGGLE) != 0) && (k % 2 == 1);
         reset           = !(((mode & M_RST) != 0) && (k == 4));
         if (((mode & M_BUSY) != 0) && (k == 2)) begin
            start = 1'b1;
            layer_S = 5'(s); layer_F = 6'(f); layer_U = 3'(u);
            layer_n = 3'(n); layer_p = 5'(p); layer_q = 3'(q);
         end else start = 1'b0;
         sample();
         check_eq("no_cfg_while_busy", pe_configure, 0);
         if (done) break;
         step();
         if (!reset) begin
            reset = 1'b1;
            sample(); check_all_zero("mid_reset"); check_eq("pe_enable_in_reset", pe_enable, 0);
            step(); sample(); check_eq("pe_enable_after_reset", pe_enable, 1);
            step();
            return;
         end
      end
      start = 1'b0; ifmap_fifo_full = 1'b0; empty_force = 1'b0;
      check_eq("done_seen", done, 1);
      check_eq("n_ifm_push", ifm_push_n, e_ifm);
      check_eq("n_flt_push", flt_push_n, e_flt);
      check_eq("n_ips_push", ips_push_n, e_psum);
      check_eq("n_ifm_read", ifm_rd_n, e_ifm);
      check_eq("n_out_wr", wr_n, e_psum);
      check_eq("done_latency", done_cyc - last_evt, 1);
      if ((mode & M_STALL) != 0) begin
         check_eq("flt_runs_in_stall", flt_stall_n > 0, 1);
         check_eq("ips_runs_in_stall", ips_stall_n > 0, 1);
      end
      step(); sample();
      check_eq("done_one_cycle", done, 0);
      check_eq("busy_after_done", busy, 0);
      check_eq("done_count", done_n, 1);
      step();
   endtask

   initial begin
      step(); step(); sample();
      check_all_zero("in_reset");
      check_eq("pe_enable_reset", pe_enable, 0);
      step(); reset = 1'b1;
      sample(); step(); sample();
      check_eq("pe_enable_released", pe_enable, 1);
      check_eq("idle_busy", busy, 0);
      step();

      // Zero-field starts must be ignored
      for (int v = 0; v < 2; v++) begin
         layer_S = (v == 0) ? 5'd3 : 5'd0; layer_F = 6'd4; layer_U = 3'd1;
         layer_n = 3'd1; layer_p = (v == 0) ? 5'd0 : 5'd4; layer_q = 3'd1;
         start = 1'b1;
         sample(); step(); start = 1'b0;
         sample();
         check_eq("zero_field_no_cfg", pe_configure, 0);
         check_eq("zero_field_idle", busy, 0);
         step();
      end

      run_layer(3, 4, 1, 1, 4, 1, 6, 3, 4, M_BUSY);
      run_layer(11, 55, 4, 1, 16, 1, 227, 44, 220, M_STALL);
      run_layer(3, 4, 1, 1, 4, 1, 6, 3, 4, M_TOGGLE);
      run_layer(3, 4, 1, 1, 4, 1, 6, 3, 4, M_RST);
      run_layer(3, 4, 1, 1, 4, 1, 6, 3, 4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
